// File: rtl/capture_ctrl_if.sv
// Capture controller bundle: control inputs, trigger sources and status/RAM outputs.
interface capture_ctrl_if #(
  parameter int unsigned NUM_CH = 5,
  parameter int unsigned LOG2   = 9
);
  logic              run;
  logic              stop;
  logic              cont;
  logic [LOG2-1:0]   trig_pos;
  logic [NUM_CH-1:0] chan_trig;
  logic              prot_trig;
  logic [NUM_CH:0]   trig_en;
  logic              trig_and;
  logic              wrt_smpl;
  logic              clr_done;
  logic              we;
  logic [LOG2-1:0]   waddr;
  logic [LOG2-1:0]   trig_addr;
  logic              armed;
  logic              triggered;
  logic              capture_done;
  logic              busy;

  // Driver side: trigger logic / host control.
  modport master (
    output run, stop, cont, trig_pos, chan_trig, prot_trig, trig_en, trig_and,
    output wrt_smpl, clr_done,
    input  we, waddr, trig_addr, armed, triggered, capture_done, busy
  );

  // Controller side.
  modport slave (
    input  run, stop, cont, trig_pos, chan_trig, prot_trig, trig_en, trig_and,
    input  wrt_smpl, clr_done,
    output we, waddr, trig_addr, armed, triggered, capture_done, busy
  );
endinterface

// File: rtl/capture_ctrl.sv
// Capture controller: combines trigger sources, sequences pre-fill / arm / post-count / done,
// and drives the shared circular RAM write address for all channel RAMs.
module capture_ctrl #(
  parameter int unsigned NUM_CH  = 5,
  parameter int unsigned ENTRIES = 384,
  parameter int unsigned LOG2    = 9
) (
  input logic           clk,
  input logic           rst,
  capture_ctrl_if.slave bus
);

  localparam logic [LOG2-1:0] LastAddr = LOG2'(ENTRIES - 1);
  localparam logic [LOG2-1:0] One      = LOG2'(1);

  typedef enum logic [2:0] {StIdle, StPre, StArmed, StPost, StDone} state_e;

  state_e          state_q, state_d;
  logic [LOG2-1:0] waddr_q, waddr_d;
  logic [LOG2-1:0] trig_addr_q, trig_addr_d;
  logic [LOG2-1:0] cnt_q, cnt_d;
  logic [LOG2-1:0] tpos_q, tpos_d;
  logic [LOG2-1:0] pre_q, pre_d;

  logic [LOG2-1:0] tpos_new;
  logic [LOG2-1:0] pre_new;
  logic [LOG2-1:0] cnt_inc;
  logic [NUM_CH:0] src;
  logic            hit;
  logic            write_en;

  // Clamp the requested post-trigger count into [1, ENTRIES-1] and derive the pre-fill length.
  always_comb begin
    tpos_new = bus.trig_pos;
    if (bus.trig_pos == '0) begin
      tpos_new = One;
    end else if (32'(bus.trig_pos) >= ENTRIES) begin
      tpos_new = LastAddr;
    end
    // pre < ENTRIES always, so the truncation is exact even when ENTRIES == 2**LOG2.
    pre_new = LOG2'(ENTRIES - 32'(tpos_new));
  end

  // Trigger combine: AND treats disabled sources as satisfied; no enabled source never fires.
  always_comb begin
    src = {bus.prot_trig, bus.chan_trig};
    if (bus.trig_and) begin
      hit = &(src | ~bus.trig_en);
    end else begin
      hit = |(src & bus.trig_en);
    end
    if (bus.trig_en == '0) begin
      hit = 1'b0;
    end
  end

  // RAM write strobe and circular address advance, same cycle as the sample strobe.
  always_comb begin
    write_en = bus.wrt_smpl &
               ((state_q == StPre) || (state_q == StArmed) || (state_q == StPost));
    waddr_d  = waddr_q;
    if (write_en) begin
      waddr_d = (waddr_q == LastAddr) ? '0 : waddr_q + One;
    end
  end

  // Capture sequencer next-state logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tpos_d      = tpos_q;
    pre_d       = pre_q;
    trig_addr_d = trig_addr_q;
    cnt_inc     = cnt_q + One;

    unique case (state_q)
      StIdle: begin
        if (bus.run) begin
          state_d = StPre;
          cnt_d   = '0;
          tpos_d  = tpos_new;
          pre_d   = pre_new;
        end
      end
      StPre: begin
        if (write_en) begin
          if (cnt_inc == pre_q) begin
            state_d = StArmed;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      StArmed: begin
        if (hit) begin
          trig_addr_d = waddr_q;
          // A write in the trigger cycle already counts as the first post sample.
          if (write_en) begin
            if (tpos_q == One) begin
              state_d = StDone;
              cnt_d   = '0;
            end else begin
              state_d = StPost;
              cnt_d   = One;
            end
          end else begin
            state_d = StPost;
            cnt_d   = '0;
          end
        end
      end
      StPost: begin
        if (write_en) begin
          if (cnt_inc == tpos_q) begin
            state_d = StDone;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      StDone: begin
        if (bus.clr_done) begin
          cnt_d = '0;
          if (bus.cont) begin
            state_d = StPre;
            tpos_d  = tpos_new;
            pre_d   = pre_new;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort overrides everything; in IDLE it also masks a coincident run.
    if (bus.stop) begin
      state_d = StIdle;
      cnt_d   = '0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      waddr_q     <= '0;
      trig_addr_q <= '0;
      cnt_q       <= '0;
      tpos_q      <= '0;
      pre_q       <= '0;
    end else begin
      state_q     <= state_d;
      waddr_q     <= waddr_d;
      trig_addr_q <= trig_addr_d;
      cnt_q       <= cnt_d;
      tpos_q      <= tpos_d;
      pre_q       <= pre_d;
    end
  end

  assign bus.we           = write_en;
  assign bus.waddr        = waddr_q;
  assign bus.trig_addr    = trig_addr_q;
  assign bus.armed        = (state_q == StArmed);
  assign bus.triggered    = (state_q == StPost);
  assign bus.capture_done = (state_q == StDone);
  assign bus.busy         = (state_q != StIdle);

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl: main instance ENTRIES=16, second instance ENTRIES=12.
module tb_capture_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  capture_ctrl_if #(.NUM_CH(5), .LOG2(4)) bus_a ();
  capture_ctrl_if #(.NUM_CH(5), .LOG2(4)) bus_b ();

  capture_ctrl #(.NUM_CH(5), .ENTRIES(16), .LOG2(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  capture_ctrl #(.NUM_CH(5), .ENTRIES(12), .LOG2(4)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n clock edges; inputs change and outputs are sampled 1ns after the edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_clr();
    bus_a.clr_done = 1'b1;
    step(1);
    bus_a.clr_done = 1'b0;
  endtask

  task automatic start_run();
    bus_a.run = 1'b1;
    step(1);
    bus_a.run = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    {bus_a.run, bus_a.stop, bus_a.cont, bus_a.prot_trig, bus_a.trig_and} = '0;
    {bus_a.wrt_smpl, bus_a.clr_done} = '0;
    bus_a.trig_pos = '0; bus_a.chan_trig = '0; bus_a.trig_en = '0;
    {bus_b.run, bus_b.stop, bus_b.cont, bus_b.prot_trig, bus_b.trig_and} = '0;
    {bus_b.wrt_smpl, bus_b.clr_done} = '0;
    bus_b.trig_pos = '0; bus_b.chan_trig = '0; bus_b.trig_en = '0;
    step(2);
    rst = 1'b0;

    check("rst_busy", bus_a.busy, 0);
    check("rst_waddr", bus_a.waddr, 0);
    check("rst_done", bus_a.capture_done, 0);

    // Basic frame: trig_pos=4, CH1 OR, CH1 high from run (early hits ignored).
    bus_a.trig_pos = 4'd4; bus_a.trig_en = 6'b000001; bus_a.trig_and = 1'b0;
    bus_a.chan_trig = 5'b00001; bus_a.wrt_smpl = 1'b1;
    start_run();
    check("t2_busy", bus_a.busy, 1);
    check("t2_we", bus_a.we, 1);
    step(11);
    check("t2_armed_early", bus_a.armed, 0);
    check("t2_waddr11", bus_a.waddr, 11);
    step(1);
    check("t2_armed", bus_a.armed, 1);
    check("t2_waddr12", bus_a.waddr, 12);
    step(1);
    check("t2_trig", bus_a.triggered, 1);
    check("t2_armed_clr", bus_a.armed, 0);
    check("t2_trig_addr", bus_a.trig_addr, 12);
    step(2);
    check("t2_done_early", bus_a.capture_done, 0);
    step(1);
    check("t2_done", bus_a.capture_done, 1);
    check("t2_waddr_done", bus_a.waddr, 0);
    check("t2_trig_addr_done", bus_a.trig_addr, 12);
    check("t2_we_done", bus_a.we, 0);
    check("t2_trig_clr", bus_a.triggered, 0);
    pulse_clr();
    check("t2_idle", bus_a.busy, 0);
    check("t2_done_clr", bus_a.capture_done, 0);

    // Reset in the middle of the post-trigger phase.
    start_run();
    step(13);
    check("t1_in_post", bus_a.triggered, 1);
    check("t1_waddr13", bus_a.waddr, 13);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("t1_we", bus_a.we, 0);
    check("t1_waddr", bus_a.waddr, 0);
    check("t1_trig_addr", bus_a.trig_addr, 0);
    check("t1_flags", {bus_a.armed, bus_a.triggered, bus_a.capture_done, bus_a.busy}, 0);

    // AND over CH1, CH2 and protocol; trigger arrives in a cycle without a write.
    bus_a.trig_en = 6'b100011; bus_a.trig_and = 1'b1; bus_a.chan_trig = 5'b00011;
    bus_a.prot_trig = 1'b0;
    start_run();
    step(12);
    check("t3_armed", bus_a.armed, 1);
    step(3);
    check("t3_no_trig", bus_a.triggered, 0);
    check("t3_waddr15", bus_a.waddr, 15);
    bus_a.prot_trig = 1'b1; bus_a.wrt_smpl = 1'b0;
    step(1);
    check("t3_trig", bus_a.triggered, 1);
    check("t3_trig_addr", bus_a.trig_addr, 15);
    check("t3_no_write", bus_a.waddr, 15);
    bus_a.wrt_smpl = 1'b1;
    step(3);
    check("t3_done_early", bus_a.capture_done, 0);
    check("t3_wrap", bus_a.waddr, 2);
    step(1);
    check("t3_done", bus_a.capture_done, 1);
    check("t3_waddr_done", bus_a.waddr, 3);
    bus_a.prot_trig = 1'b0;
    pulse_clr();

    // trig_pos=0 behaves as 1: pre=15, done on the trigger write.
    bus_a.trig_pos = 4'd0; bus_a.trig_en = 6'b000001; bus_a.trig_and = 1'b0;
    bus_a.chan_trig = 5'b00001;
    start_run();
    step(14);
    check("t4_armed_early", bus_a.armed, 0);
    step(1);
    check("t4_armed", bus_a.armed, 1);
    check("t4_waddr_armed", bus_a.waddr, 2);
    step(1);
    check("t4_done", bus_a.capture_done, 1);
    check("t4_trig_addr", bus_a.trig_addr, 2);
    check("t4_waddr_done", bus_a.waddr, 3);
    pulse_clr();

    // trig_en=0 never triggers even with every source high under AND.
    bus_a.trig_pos = 4'd4; bus_a.trig_en = 6'b000000; bus_a.trig_and = 1'b1;
    bus_a.chan_trig = 5'b11111; bus_a.prot_trig = 1'b1;
    start_run();
    step(12);
    check("t4_en0_armed", bus_a.armed, 1);
    step(10);
    check("t4_en0_no_trig", bus_a.triggered, 0);
    check("t4_en0_waddr", bus_a.waddr, 9);

    // Stop while armed, then run+stop together from IDLE.
    bus_a.wrt_smpl = 1'b0; bus_a.stop = 1'b1;
    step(1);
    bus_a.stop = 1'b0;
    check("t6_stop_busy", bus_a.busy, 0);
    check("t6_stop_armed", bus_a.armed, 0);
    check("t6_stop_waddr", bus_a.waddr, 9);
    step(2);
    check("t6_stop_done", bus_a.capture_done, 0);
    bus_a.run = 1'b1; bus_a.stop = 1'b1;
    step(1);
    bus_a.run = 1'b0; bus_a.stop = 1'b0;
    check("t6_runstop", bus_a.busy, 0);

    // Continuous mode: two frames, second with trig_pos re-latched to 6.
    bus_a.cont = 1'b1; bus_a.trig_en = 6'b000001; bus_a.trig_and = 1'b0;
    bus_a.chan_trig = 5'b00001; bus_a.prot_trig = 1'b0; bus_a.wrt_smpl = 1'b1;
    start_run();
    step(16);
    check("t5_done1", bus_a.capture_done, 1);
    check("t5_waddr1", bus_a.waddr, 9);
    check("t5_trig_addr1", bus_a.trig_addr, 5);
    bus_a.trig_pos = 4'd6;
    pulse_clr();
    check("t5_rearm_done", bus_a.capture_done, 0);
    check("t5_rearm_busy", bus_a.busy, 1);
    step(9);
    check("t5_armed_early", bus_a.armed, 0);
    step(1);
    check("t5_armed", bus_a.armed, 1);
    step(1);
    check("t5_trig_addr2", bus_a.trig_addr, 3);
    step(5);
    check("t5_done2", bus_a.capture_done, 1);
    check("t5_waddr2", bus_a.waddr, 9);
    bus_a.cont = 1'b0;
    pulse_clr();
    check("t5_idle", bus_a.busy, 0);

    // ENTRIES=12: trig_pos=14 clamps to 11, pre=1, address wraps 11->0.
    bus_b.trig_pos = 4'd14; bus_b.trig_en = 6'b000001; bus_b.chan_trig = 5'b00001;
    bus_b.wrt_smpl = 1'b1; bus_b.run = 1'b1;
    step(1);
    bus_b.run = 1'b0;
    step(1);
    check("b_armed", bus_b.armed, 1);
    check("b_waddr1", bus_b.waddr, 1);
    step(1);
    check("b_trig", bus_b.triggered, 1);
    check("b_trig_addr", bus_b.trig_addr, 1);
    step(9);
    check("b_done_early", bus_b.capture_done, 0);
    check("b_waddr11", bus_b.waddr, 11);
    step(1);
    check("b_done", bus_b.capture_done, 1);
    check("b_wrap", bus_b.waddr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
